// File: rtl/aes_comb.sv
// rtl/aes_comb.sv - iterative AES-128 engine, one round per cycle; decrypt path built when AES_DECRYPT_EN is defined
module aes_comb (
    input  logic         HCLK,
    input  logic         n_rst,
    input  logic         keyEna,
    input  logic         encrypt,
    input  logic [127:0] keyword,
    input  logic [127:0] input_data,
    output logic [127:0] AESresult
);
    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

    state_t        state, state_nx;
    logic          ena_q;
    logic          armed;
    logic [3:0]    cnt;
    logic [127:0]  data_q;
    logic [127:0]  st;
    logic [127:0]  rk [0:10];
    logic [127:0]  key_nx;
    logic [127:0]  init_nx;
    logic [127:0]  round_nx;
    logic          start;
`ifdef AES_DECRYPT_EN
    logic          mode_q;
`else
    logic          unused_encrypt;
    assign unused_encrypt = encrypt;
`endif

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] a, o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        o = a;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = a[127-32*c -: 8];
                a1 = a[119-32*c -: 8];
                a2 = a[111-32*c -: 8];
                a3 = a[103-32*c -: 8];
                o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return o ^ k;
    endfunction

`ifdef AES_DECRYPT_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] a, o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
        a = a ^ k;
        o = a;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = a[127-32*c -: 8];
                a1 = a[119-32*c -: 8];
                a2 = a[111-32*c -: 8];
                a3 = a[103-32*c -: 8];
                o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        return o;
    endfunction
`endif

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // a start needs keyEna seen low since reset, so a level held through reset never triggers
    assign start = keyEna && !ena_q && armed;

    // next-state selection for the operation sequencer
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = KEYEXP;
            KEYEXP:  if (cnt == 4'd10) state_nx = INIT;
            INIT:    state_nx = ROUND;
            ROUND:   if (cnt == 4'd10) state_nx = DONE;
            DONE:    if (!keyEna) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: next round key, initial whitening and one cipher round
    always_comb begin
        key_nx = expand(rk[cnt - 4'd1], rcon(cnt));
`ifdef AES_DECRYPT_EN
        init_nx  = data_q ^ (mode_q ? rk[0] : rk[10]);
        round_nx = mode_q ? enc_round(st, rk[cnt], cnt == 4'd10)
                          : dec_round(st, rk[4'd10 - cnt], cnt == 4'd10);
`else
        init_nx  = data_q ^ rk[0];
        round_nx = enc_round(st, rk[cnt], cnt == 4'd10);
`endif
    end

    // state register plus captured operands, key schedule, round state and result
    always_ff @(posedge HCLK) begin
        if (n_rst) begin
            state     <= IDLE;
            ena_q     <= 1'b0;
            armed     <= 1'b0;
            cnt       <= 4'd0;
            data_q    <= '0;
            st        <= '0;
            AESresult <= '0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
`ifdef AES_DECRYPT_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            ena_q <= keyEna;
            if (!keyEna) armed <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    rk[0]  <= keyword;
                    data_q <= input_data;
                    cnt    <= 4'd1;
`ifdef AES_DECRYPT_EN
                    mode_q <= encrypt;
`endif
                end
                KEYEXP: begin
                    rk[cnt] <= key_nx;
                    cnt     <= (cnt == 4'd10) ? 4'd1 : cnt + 4'd1;
                end
                INIT: st <= init_nx;
                ROUND: begin
                    st  <= round_nx;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd10) AESresult <= round_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_comb.sv
// tb/tb_aes_comb.sv - directed-vector bench for aes_comb
module tb_aes_comb;
    logic         tb_HCLK;
    logic         n_rst;
    logic         keyEna;
    logic         encrypt;
    logic [127:0] keyword;
    logic [127:0] input_data;
    logic [127:0] AESresult;

    int checks;
    int failures;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_comb dut (
        .HCLK       (tb_HCLK),
        .n_rst      (n_rst),
        .keyEna     (keyEna),
        .encrypt    (encrypt),
        .keyword    (keyword),
        .input_data (input_data),
        .AESresult  (AESresult)
    );

    initial tb_HCLK = 1'b0;
    always #5 tb_HCLK = ~tb_HCLK;

    task automatic run_op(input logic [127:0] k, input logic [127:0] d, input logic e,
                          output logic [127:0] pre, output logic [127:0] post);
        @(negedge tb_HCLK);
        keyword    = k;
        input_data = d;
        encrypt    = e;
        keyEna     = 1'b1;
        repeat (21) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        pre = AESresult;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        post = AESresult;
        keyEna = 1'b0;
        @(posedge tb_HCLK);
    endtask

    task automatic test_reset();
        n_rst      = 1'b1;
        keyEna     = 1'b1;
        encrypt    = 1'b1;
        keyword    = FK;
        input_data = FP;
        repeat (3) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        checks++;
        if (AESresult !== 128'h0) begin
            failures++;
            $display("FAIL reset_value actual=%h required=%h", AESresult, 128'h0);
        end
        n_rst = 1'b0;
        repeat (30) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        checks++;
        if (AESresult !== 128'h0) begin
            failures++;
            $display("FAIL no_start_level_high actual=%h required=%h", AESresult, 128'h0);
        end
        keyEna = 1'b0;
        @(posedge tb_HCLK);
    endtask

    task automatic test_fips_encrypt();
        logic [127:0] pre, post;
        run_op(FK, FP, 1'b1, pre, post);
        checks++;
        if (pre !== 128'h0) begin
            failures++;
            $display("FAIL fips_enc_latency actual=%h required=%h", pre, 128'h0);
        end
        checks++;
        if (post !== FC) begin
            failures++;
            $display("FAIL fips_enc actual=%h required=%h", post, FC);
        end
    endtask

    task automatic test_fips_decrypt();
        logic [127:0] pre, post;
`ifdef AES_DECRYPT_EN
        run_op(FK, FC, 1'b0, pre, post);
        checks++;
        if (post !== FP) begin
            failures++;
            $display("FAIL fips_dec actual=%h required=%h", post, FP);
        end
`else
        run_op(FK, FP, 1'b0, pre, post);
        checks++;
        if (post !== FC) begin
            failures++;
            $display("FAIL fips_mode_ignored actual=%h required=%h", post, FC);
        end
`endif
    endtask

    task automatic test_vectors();
        logic [127:0] keys [3];
        logic [127:0] dats [3];
        logic [127:0] encs [3];
        logic [127:0] decs [3];
        logic [127:0] pre, post, exp_d;
        keys[0] = 128'h11111111111111111111111111111111;
        dats[0] = 128'h0;
        encs[0] = 128'he0d541314e00102d6dfca8bc007b6c8a;
        decs[0] = 128'h5e749c2d64e5ef78279337670223fc08;
        keys[1] = 128'h00112233445566778899aabbccddeeff;
        dats[1] = 128'haeaeaeaeaeaeaeaeaeaeaeaeaeaeaeae;
        encs[1] = 128'h4adf494c4a532e3f53a701e95e4fbdf2;
        decs[1] = 128'h3692a0c4262ca8352c646926d61d60f9;
        keys[2] = 128'haabbccddeeffaabbccddeeffaabbccdd;
        dats[2] = 128'h00110022003300440055006600770088;
        encs[2] = 128'hb1a1d2bf4e05de15f8176bfdf81836bf;
        decs[2] = 128'hb492794dbcb5aca13d796b4eddea21c1;
        for (int i = 0; i < 3; i++) begin
            run_op(keys[i], dats[i], 1'b1, pre, post);
            checks++;
            if (post !== encs[i]) begin
                failures++;
                $display("FAIL vec%0d_enc actual=%h required=%h", i, post, encs[i]);
            end
`ifdef AES_DECRYPT_EN
            exp_d = decs[i];
`else
            exp_d = encs[i];
`endif
            run_op(keys[i], dats[i], 1'b0, pre, post);
            checks++;
            if (post !== exp_d) begin
                failures++;
                $display("FAIL vec%0d_dec actual=%h required=%h", i, post, exp_d);
            end
        end
    endtask

    task automatic test_midop_change();
        logic [127:0] prev, pre, post;
        prev = AESresult;
        @(negedge tb_HCLK);
        keyword    = 128'haabbccddeeffaabbccddeeffaabbccdd;
        input_data = 128'h00110022003300440055006600770088;
        encrypt    = 1'b1;
        keyEna     = 1'b1;
        repeat (5) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        keyword    = 128'h0;
        input_data = 128'hffeeddccbbaa99887766554433221100;
        encrypt    = 1'b0;
        keyEna     = 1'b0;
        repeat (16) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        pre = AESresult;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        post = AESresult;
        checks++;
        if (pre !== prev) begin
            failures++;
            $display("FAIL midop_held actual=%h required=%h", pre, prev);
        end
        checks++;
        if (post !== 128'hb1a1d2bf4e05de15f8176bfdf81836bf) begin
            failures++;
            $display("FAIL midop_result actual=%h required=%h", post, 128'hb1a1d2bf4e05de15f8176bfdf81836bf);
        end
        @(posedge tb_HCLK);
    endtask

    task automatic test_hold_high();
        logic [127:0] r;
        @(negedge tb_HCLK);
        keyword    = 128'h11111111111111111111111111111111;
        input_data = 128'h0;
        encrypt    = 1'b1;
        keyEna     = 1'b1;
        repeat (22) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        r = AESresult;
        checks++;
        if (r !== 128'he0d541314e00102d6dfca8bc007b6c8a) begin
            failures++;
            $display("FAIL hold_result actual=%h required=%h", r, 128'he0d541314e00102d6dfca8bc007b6c8a);
        end
        input_data = FP;
        keyword    = FK;
        repeat (40) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        checks++;
        if (AESresult !== 128'he0d541314e00102d6dfca8bc007b6c8a) begin
            failures++;
            $display("FAIL hold_no_restart actual=%h required=%h", AESresult, 128'he0d541314e00102d6dfca8bc007b6c8a);
        end
        keyEna = 1'b0;
        @(posedge tb_HCLK);
    endtask

    task automatic test_reset_midop();
        logic [127:0] pre, post;
        @(negedge tb_HCLK);
        keyword    = 128'h00112233445566778899aabbccddeeff;
        input_data = 128'haeaeaeaeaeaeaeaeaeaeaeaeaeaeaeae;
        encrypt    = 1'b1;
        keyEna     = 1'b1;
        repeat (16) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        n_rst = 1'b1;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        checks++;
        if (AESresult !== 128'h0) begin
            failures++;
            $display("FAIL midop_reset actual=%h required=%h", AESresult, 128'h0);
        end
        n_rst  = 1'b0;
        keyEna = 1'b0;
        @(posedge tb_HCLK);
        run_op(FK, FP, 1'b1, pre, post);
        checks++;
        if (pre !== 128'h0) begin
            failures++;
            $display("FAIL after_reset_latency actual=%h required=%h", pre, 128'h0);
        end
        checks++;
        if (post !== FC) begin
            failures++;
            $display("FAIL after_reset_result actual=%h required=%h", post, FC);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fips_encrypt();
        test_fips_decrypt();
        test_vectors();
        test_midop_change();
        test_hold_high();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_comb.md
# aes_comb

Iterative AES-128 encrypt/decrypt engine. It captures a 128-bit key, a 128-bit data block and a mode bit on a start request. It expands the key schedule, runs ten rounds one round per cycle, and registers the 128-bit result. The block sits behind the bus-side register interface: that interface supplies key, data and mode and reads back the result.

## Interface
- No parameters.
- HCLK  input  1  Single system clock; all state updates on its rising edge.
- n_rst  input  1  Reset, synchronous and active-high. Sampled on the HCLK rising edge; 1 = reset.
- keyEna  input  1  Start/enable level. A 0→1 transition seen while idle starts one operation.
- encrypt  input  1  Mode, sampled at the start edge: 1 = encrypt (FIPS-197 Cipher), 0 = decrypt (InvCipher).
- keyword  input  128  AES-128 cipher key. Bit 127 is the first key byte's MSB (FIPS-197 byte order).
- input_data  input  128  Plaintext (encrypt) or ciphertext (decrypt), same byte order.
- AESresult  output  128  Registered result; holds its value between operations.

## Operation
- States: IDLE, KEYEXP, INIT, ROUND, DONE.
- IDLE:
  - On an edge where keyEna=1 and the previously sampled keyEna=0, capture keyword, input_data and encrypt into internal registers.
  - Load rk0 = key and go to KEYEXP.
- KEYEXP:
  - 10 cycles; each cycle computes and stores the next round key rk1..rk10.
  - Standard schedule: RotWord, SubWord, Rcon = 01,02,04,08,10,20,40,80,1b,36.
- INIT, one cycle:
  - Encrypt: state = data ^ rk0.
  - Decrypt: state = data ^ rk10.
- ROUND, 10 cycles, round counter r = 1..10:
  - Encrypt: SubBytes, ShiftRows, MixColumns (omitted when r=10), then AddRoundKey with rk[r].
  - Decrypt: InvShiftRows, InvSubBytes, AddRoundKey with rk[10−r], then InvMixColumns (omitted when r=10).
  - The edge that completes r=10 writes AESresult; go to DONE.
- DONE: AESresult holds. Return to IDLE when keyEna=0.
- A new operation requires keyEna low for at least one sampled edge, then high again.
- keyEna, keyword, input_data and encrypt changes after the capture edge are ignored until the operation finishes. Deasserting keyEna mid-operation does not abort it.
- S-box/inverse S-box may be tables or GF(2^8) inversion plus affine map; results must be bit-exact to FIPS-197.
- Reset, in any state, including mid-operation: state becomes IDLE, AESresult = 0, round keys and counter cleared, the previously-sampled keyEna register = 0.

## Timing
- Capture edge = edge C.
- KEYEXP occupies edges C+1..C+10.
- INIT is edge C+11.
- Rounds occupy edges C+12..C+21.
- AESresult is valid after edge C+21: 21 cycles of latency, identical for both modes.
- With keyEna raised just after an edge, C is the next edge, so the result is readable after the 22nd edge from the assertion.
- Throughput: one block per 22 cycles, plus at least one cycle with keyEna low.
- AESresult changes only at edge C+21 or on reset; it is never driven with intermediate round state.
- If keyEna is already high when reset releases, no operation starts until keyEna falls and rises again.

## Configuration
- AES_DECRYPT_EN defined: decrypt path built (inverse S-box, InvShiftRows, InvMixColumns, reversed key order); encrypt=0 performs decryption.
- AES_DECRYPT_EN undefined: decrypt hardware omitted. The encrypt input is ignored and every operation encrypts. Latency is unchanged.

## Test plan
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, encrypt=1 → AESresult 69c4e0d86a7b0430d8cdb78070b4c55a after 22 edges.
- FIPS-197 decrypt: same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, encrypt=0 → 00112233445566778899aabbccddeeff.
- Key 11111111111111111111111111111111, data all-zero:
  - encrypt → e0d541314e00102d6dfca8bc007b6c8a.
  - decrypt → 5e749c2d64e5ef78279337670223fc08.
- Key 00112233445566778899aabbccddeeff, data aeaeaeaeaeaeaeaeaeaeaeaeaeaeaeae:
  - encrypt → 4adf494c4a532e3f53a701e95e4fbdf2.
  - decrypt → 3692a0c4262ca8352c646926d61d60f9.
- Key aabbccddeeffaabbccddeeffaabbccdd, data 00110022003300440055006600770088:
  - encrypt → b1a1d2bf4e05de15f8176bfdf81836bf.
  - decrypt → b492794dbcb5aca13d796b4eddea21c1.
- Control corners:
  - Change input_data mid-operation → result still matches the captured data.
  - Hold keyEna high after DONE → no restart; result held.
  - Assert n_rst at round 5 → AESresult=0, IDLE; the next keyEna rise completes normally.
